// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Segment patterns are active-high {a,b,c,d,e,f,g}; polarity is applied by the user.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h7E;
      4'h1:    pattern = 7'h30;
      4'h2:    pattern = 7'h6D;
      4'h3:    pattern = 7'h79;
      4'h4:    pattern = 7'h33;
      4'h5:    pattern = 7'h5B;
      4'h6:    pattern = 7'h5F;
      4'h7:    pattern = 7'h70;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h7B;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h1F;
      4'hC:    pattern = 7'h4E;
      4'hD:    pattern = 7'h3D;
      4'hE:    pattern = 7'h4F;
      default: pattern = 7'h47;
    endcase
    return pattern;
  endfunction

  // Counter width for a 0..div-1 prescaler; never narrower than one bit.
  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high a..g segment decoder.
import seg_pkg::*;

module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display driver with frame-synchronous shadow update.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
import seg_pkg::*;

module seg_scan_driver #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DIGITS         = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid,
  input  logic [4*DIGITS-1:0]   upd_data,
  input  logic [DIGITS-1:0]     upd_dp,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = div_width(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_MASK  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] SEL_MASK = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_data;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_v;

  logic                tick;
  logic                boundary;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic [6:0]          cur_seg;
  logic [DIGITS-1:0]   sel_onehot;
  logic [DIGITS-1:0]   lz_mask;

  assign tick     = (presc == CNT_MAX);
  assign boundary = tick && (idx == IDX_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
    end
  end

  // An update landing exactly on the boundary tick goes straight to the shadow,
  // otherwise it waits in pending until the next frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_v      <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else begin
      if (upd_valid) begin
        pend_data <= upd_data;
        pend_dp   <= upd_dp;
      end
      if (boundary && upd_valid) begin
        shadow_data <= upd_data;
        shadow_dp   <= upd_dp;
        pend_v      <= 1'b0;
      end else if (boundary && pend_v) begin
        shadow_data <= pend_data;
        shadow_dp   <= pend_dp;
        pend_v      <= 1'b0;
      end else if (upd_valid) begin
        pend_v <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit is blanked while every nibble above
  // and including it is zero. Digit 0 always shows.
  always_comb begin
    logic zeros_above;
    zeros_above = 1'b1;
    lz_mask     = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeros_above = zeros_above && (shadow_data[i*4 +: 4] == 4'h0);
      lz_mask[i]  = zeros_above;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib       = shadow_data[i*4 +: 4];
        cur_dp        = shadow_dp[i];
        cur_lz        = lz_mask[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  hex_to_seg7 u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF ^ SEG_MASK;
      dp         <= DP_MASK;
      sel        <= SEL_MASK;
      frame_done <= 1'b0;
    end else begin
      seg        <= ((blank || cur_lz) ? SEG_OFF : cur_seg) ^ SEG_MASK;
      dp         <= (blank ? 1'b0 : cur_dp) ^ DP_MASK;
      sel        <= sel_onehot ^ SEL_MASK;
      frame_done <= boundary;
    end
  end

endmodule
